pred_pmu_mc: RTL and testbench
==============================

Name: pred_pmu_mc

Overview:
- Multi-channel branch-prediction performance monitor. One channel per branch class, e.g. cond, jal, jalr, ret.
- Each channel counts resolved predictions and mispredictions reported by EX.
- Adds four things per channel: selectable saturate/wrap arithmetic, sticky overflow flags, global enable/clear, and snapshot registers captured on request or on a programmable cycle window.
- Sits beside the EX stage; its outputs are read by the debug/CSR path.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- CNT_W, 32, width of every live and snapshot counter (8..64).
- SATURATE, 1, 1 = counters hold at all-ones; 0 = counters wrap to 0.
- WIN_W, 16, width of the window-length input and the internal window cycle counter.
- SEL_W, clog2(NUM_CH) with minimum 1, width of rd_sel.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  counting enable; when 0, live counters and the window counter hold.
- clear  in  1  synchronous pulse; zeroes live counters, ovf flags and the window counter.
- fb_valid  in  NUM_CH  per-channel prediction-resolved strobe.
- fb_incorrect  in  NUM_CH  per-channel mispredict qualifier; ignored unless the matching fb_valid is 1.
- snap_req  in  1  manual snapshot request pulse.
- window_len  in  WIN_W  auto-snapshot period in enabled cycles; 0 disables auto snapshots.
- rd_sel  in  SEL_W  channel select for the read outputs.
- rd_total  out  CNT_W  live total count of the selected channel.
- rd_wrong  out  CNT_W  live wrong count of the selected channel.
- rd_snap_total  out  CNT_W  snapshot total count of the selected channel.
- rd_snap_wrong  out  CNT_W  snapshot wrong count of the selected channel.
- snap_valid  out  1  set by the first snapshot after reset.
- snap_pulse  out  1  one-cycle strobe in the cycle the snapshot registers update.
- ovf  out  NUM_CH  sticky per-channel overflow flag.

Behaviour:
- Reset (rst_n=0, asynchronous): all live counters, snapshot registers, ovf, snap_valid, snap_pulse and the window counter go to 0 immediately. Reset mid-window discards that window.
- Increment rules:
  - Per channel c with enable=1: total_c += 1 when fb_valid[c]=1.
  - wrong_c += 1 when fb_valid[c] and fb_incorrect[c] are both 1.
  - All channels update in parallel in the same cycle.
- Overflow:
  - SATURATE=1: an increment at all-ones leaves the counter at all-ones and sets ovf[c].
  - SATURATE=0: the counter wraps to 0 and ovf[c] is set.
  - ovf[c] is sticky; only clear or reset zeroes it. Either counter of the channel (total or wrong) can set it.
- Window counter:
  - Disabled when window_len=0.
  - Otherwise it increments on each enable=1 cycle. When its value is >= window_len-1 it returns to 0 and raises an auto-snapshot in that cycle.
  - Because the compare is >=, lowering window_len mid-window fires on the next enabled cycle.
- Snapshot trigger = snap_req OR auto-snapshot; a snapshot is taken regardless of enable.
  - On the clock edge of the trigger cycle, every snapshot register loads the live register value from before that edge. Events in the trigger cycle are counted live but are not in the snapshot.
  - snap_pulse is high for the following cycle. snap_valid is set and stays set until reset.
  - Snapshots never modify live counters.
- clear:
  - clear with a trigger in the same cycle: the snapshot captures the pre-clear values, and the live counters become 0. Events in that cycle are discarded.
  - clear has priority over increments.
  - clear leaves the snapshot registers and snap_valid unchanged.
- Read path:
  - The four rd_* outputs are a combinational mux of registers, with zero latency from rd_sel.
  - An rd_sel value >= NUM_CH returns 0 on all four outputs.
- Invariant: wrong_c <= total_c at all times when SATURATE=1 and there is no overflow.

Test Plan:
- Reset, then enable=1, fb_valid[0]=1 for 10 cycles with fb_incorrect[0]=1 on 3 of them, rd_sel=0 -> rd_total=10, rd_wrong=3; other channels read 0.
- fb_incorrect[2]=1 with fb_valid[2]=0 for 5 cycles -> channel 2 wrong=0, total=0.
- CNT_W=8, SATURATE=1, 300 valid events on ch1 -> rd_total=255, ovf[1]=1. Repeat with SATURATE=0 -> rd_total=44, ovf[1]=1. Then clear -> rd_total=0, ovf=0.
- window_len=4, enable=1, fb_valid[0] held 1 -> snap_pulse every 4 cycles, with rd_snap_total = 4, 8, 12; snap_valid=1 after the first.
- snap_req and clear in the same cycle with live total=7 and a valid event in that cycle -> rd_snap_total=7, rd_total=0 on the next cycle.
- Assert rst_n mid-count (total=5, snapshot=3) -> all outputs 0 immediately, without waiting for clk; rd_sel=NUM_CH returns 0 afterwards.

Source files
------------

// File: rtl/pred_pmu_mc.sv
// Multi-channel branch-prediction performance monitor: per-channel total/wrong
// counters with sticky overflow, manual/windowed snapshots and a muxed read port.
module pred_pmu_mc #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1,
  parameter int unsigned WIN_W    = 16,
  parameter int unsigned SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] fb_valid,
  input  logic [NUM_CH-1:0] fb_incorrect,
  input  logic              snap_req,
  input  logic [WIN_W-1:0]  window_len,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_total,
  output logic [CNT_W-1:0]  rd_wrong,
  output logic [CNT_W-1:0]  rd_snap_total,
  output logic [CNT_W-1:0]  rd_snap_wrong,
  output logic              snap_valid,
  output logic              snap_pulse,
  output logic [NUM_CH-1:0] ovf
);

  logic [CNT_W-1:0]  total_q      [NUM_CH];
  logic [CNT_W-1:0]  wrong_q      [NUM_CH];
  logic [CNT_W-1:0]  snap_total_q [NUM_CH];
  logic [CNT_W-1:0]  snap_wrong_q [NUM_CH];
  logic [CNT_W-1:0]  total_d      [NUM_CH];
  logic [CNT_W-1:0]  wrong_d      [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              auto_snap;
  logic              trigger;
  logic              snap_valid_q;
  logic              snap_pulse_q;

  // Returns {overflowed, next_value} for a single increment.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
    logic [CNT_W:0] r;
    if (v != '1)       r = {1'b0, v + CNT_W'(1)};
    else if (SATURATE) r = {1'b1, v};
    else               r = {1'b1, {CNT_W{1'b0}}};
    return r;
  endfunction

  always_comb begin
    logic [CNT_W:0] t_nx;
    logic [CNT_W:0] w_nx;
    t_nx  = '0;
    w_nx  = '0;
    ovf_d = ovf_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      total_d[c] = total_q[c];
      wrong_d[c] = wrong_q[c];
      t_nx       = bump(total_q[c]);
      w_nx       = bump(wrong_q[c]);
      if (clear) begin
        total_d[c] = '0;
        wrong_d[c] = '0;
        ovf_d[c]   = 1'b0;
      end else if (enable && fb_valid[c]) begin
        total_d[c] = t_nx[CNT_W-1:0];
        ovf_d[c]   = ovf_d[c] | t_nx[CNT_W];
        if (fb_incorrect[c]) begin
          wrong_d[c] = w_nx[CNT_W-1:0];
          ovf_d[c]   = ovf_d[c] | w_nx[CNT_W];
        end
      end
    end
  end

  // The >= compare lets a shortened window fire on the very next enabled cycle.
  always_comb begin
    win_d     = win_q;
    auto_snap = 1'b0;
    if (enable && (window_len != '0)) begin
      if (win_q >= window_len - WIN_W'(1)) begin
        win_d     = '0;
        auto_snap = 1'b1;
      end else begin
        win_d = win_q + WIN_W'(1);
      end
    end
    if (clear) win_d = '0;
  end

  assign trigger = snap_req | auto_snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        total_q[c]      <= '0;
        wrong_q[c]      <= '0;
        snap_total_q[c] <= '0;
        snap_wrong_q[c] <= '0;
      end
      ovf_q        <= '0;
      win_q        <= '0;
      snap_valid_q <= 1'b0;
      snap_pulse_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        total_q[c] <= total_d[c];
        wrong_q[c] <= wrong_d[c];
        if (trigger) begin
          snap_total_q[c] <= total_q[c];
          snap_wrong_q[c] <= wrong_q[c];
        end
      end
      ovf_q        <= ovf_d;
      win_q        <= win_d;
      snap_valid_q <= snap_valid_q | trigger;
      snap_pulse_q <= trigger;
    end
  end

  always_comb begin
    rd_total      = '0;
    rd_wrong      = '0;
    rd_snap_total = '0;
    rd_snap_wrong = '0;
    if (32'(rd_sel) < NUM_CH) begin
      rd_total      = total_q[rd_sel];
      rd_wrong      = wrong_q[rd_sel];
      rd_snap_total = snap_total_q[rd_sel];
      rd_snap_wrong = snap_wrong_q[rd_sel];
    end
  end

  assign snap_valid = snap_valid_q;
  assign snap_pulse = snap_pulse_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_pred_pmu_mc.sv
// Self-checking bench for pred_pmu_mc: a 3-channel 32-bit instance checked
// against a behavioural model with a snapshot scoreboard, plus two 8-bit
// instances (saturating and wrapping) for the overflow corners.
module tb_pred_pmu_mc;

  localparam int unsigned NCH = 3;

  typedef struct packed {
    logic [NCH-1:0][31:0] tot;
    logic [NCH-1:0][31:0] wrg;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic [3:0]  fb_valid;
  logic [3:0]  fb_incorrect;
  logic        snap_req;
  logic [15:0] window_len;
  logic [1:0]  rd_sel;

  logic [31:0]    rd_total, rd_wrong, rd_snap_total, rd_snap_wrong;
  logic           snap_valid, snap_pulse;
  logic [NCH-1:0] ovf;

  logic [7:0] s_total, s_wrong, s_snap_total, s_snap_wrong;
  logic       s_snap_valid, s_snap_pulse;
  logic [3:0] s_ovf;
  logic [7:0] w_total, w_wrong, w_snap_total, w_snap_wrong;
  logic       w_snap_valid, w_snap_pulse;
  logic [3:0] w_ovf;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] m_total [NCH];
  logic [31:0] m_wrong [NCH];
  logic [15:0] m_win;
  logic        m_pulse;
  logic        m_snap_valid;
  snap_t       sq [$];

  always #5 clk = ~clk;

  pred_pmu_mc #(.NUM_CH(NCH), .CNT_W(32), .SATURATE(1'b1), .WIN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .fb_valid(fb_valid[NCH-1:0]), .fb_incorrect(fb_incorrect[NCH-1:0]),
    .snap_req(snap_req), .window_len(window_len), .rd_sel(rd_sel),
    .rd_total(rd_total), .rd_wrong(rd_wrong),
    .rd_snap_total(rd_snap_total), .rd_snap_wrong(rd_snap_wrong),
    .snap_valid(snap_valid), .snap_pulse(snap_pulse), .ovf(ovf)
  );

  pred_pmu_mc #(.NUM_CH(4), .CNT_W(8), .SATURATE(1'b1), .WIN_W(16)) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .fb_valid(fb_valid), .fb_incorrect(fb_incorrect),
    .snap_req(snap_req), .window_len(window_len), .rd_sel(rd_sel),
    .rd_total(s_total), .rd_wrong(s_wrong),
    .rd_snap_total(s_snap_total), .rd_snap_wrong(s_snap_wrong),
    .snap_valid(s_snap_valid), .snap_pulse(s_snap_pulse), .ovf(s_ovf)
  );

  pred_pmu_mc #(.NUM_CH(4), .CNT_W(8), .SATURATE(1'b0), .WIN_W(16)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .fb_valid(fb_valid), .fb_incorrect(fb_incorrect),
    .snap_req(snap_req), .window_len(window_len), .rd_sel(rd_sel),
    .rd_total(w_total), .rd_wrong(w_wrong),
    .rd_snap_total(w_snap_total), .rd_snap_wrong(w_snap_wrong),
    .snap_valid(w_snap_valid), .snap_pulse(w_snap_pulse), .ovf(w_ovf)
  );

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_total[c] = '0;
      m_wrong[c] = '0;
    end
    m_win        = '0;
    m_pulse      = 1'b0;
    m_snap_valid = 1'b0;
    sq.delete();
  endtask

  // Advance the model with the current inputs, then clock the DUTs and settle.
  task automatic step_clk();
    snap_t       s;
    logic        auto_s;
    logic        trig;
    logic [15:0] win_n;
    auto_s = 1'b0;
    win_n  = m_win;
    if (enable && window_len != 16'd0) begin
      if (m_win >= window_len - 16'd1) begin
        win_n  = 16'd0;
        auto_s = 1'b1;
      end else begin
        win_n = m_win + 16'd1;
      end
    end
    trig = snap_req | auto_s;
    if (trig) begin
      for (int c = 0; c < NCH; c++) begin
        s.tot[c] = m_total[c];
        s.wrg[c] = m_wrong[c];
      end
      sq.push_back(s);
      m_snap_valid = 1'b1;
    end
    for (int c = 0; c < NCH; c++) begin
      if (clear) begin
        m_total[c] = '0;
        m_wrong[c] = '0;
      end else if (enable && fb_valid[c]) begin
        m_total[c] = m_total[c] + 32'd1;
        if (fb_incorrect[c]) m_wrong[c] = m_wrong[c] + 32'd1;
      end
    end
    if (clear) win_n = 16'd0;
    m_win   = win_n;
    m_pulse = trig;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; snap_req = 1'b0;
    fb_valid = '0; fb_incorrect = '0; window_len = '0; rd_sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (rd_total !== 32'd0 || rd_wrong !== 32'd0 || rd_snap_total !== 32'd0 || rd_snap_wrong !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_counts: got %0d/%0d/%0d/%0d want 0/0/0/0", rd_total, rd_wrong, rd_snap_total, rd_snap_wrong);
    end
    vectors++;
    if (snap_valid !== 1'b0 || snap_pulse !== 1'b0 || ovf !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got valid=%b pulse=%b ovf=%b want 0 0 000", snap_valid, snap_pulse, ovf);
    end
    rst_n = 1'b1;
    step_clk();
  endtask

  task automatic test_basic();
    enable = 1'b1;
    rd_sel = 2'd0;
    for (int i = 0; i < 10; i++) begin
      fb_valid     = 4'b0001;
      fb_incorrect = (i == 2 || i == 5 || i == 8) ? 4'b0001 : 4'b0000;
      step_clk();
    end
    fb_valid = '0; fb_incorrect = '0;
    vectors++;
    if (rd_total !== m_total[0] || rd_total !== 32'd10) begin
      miscompares++;
      $display("FAIL basic_total: got %0d want %0d", rd_total, m_total[0]);
    end
    vectors++;
    if (rd_wrong !== m_wrong[0] || rd_wrong !== 32'd3) begin
      miscompares++;
      $display("FAIL basic_wrong: got %0d want %0d", rd_wrong, m_wrong[0]);
    end
    for (int c = 1; c < NCH; c++) begin
      rd_sel = 2'(c);
      #1;
      vectors++;
      if (rd_total !== m_total[c] || rd_wrong !== m_wrong[c]) begin
        miscompares++;
        $display("FAIL basic_other_ch%0d: got %0d/%0d want %0d/%0d", c, rd_total, rd_wrong, m_total[c], m_wrong[c]);
      end
    end
    rd_sel = 2'd0;
  endtask

  task automatic test_ignore_incorrect();
    fb_valid     = 4'b0000;
    fb_incorrect = 4'b0100;
    repeat (5) step_clk();
    fb_incorrect = '0;
    rd_sel = 2'd2;
    #1;
    vectors++;
    if (rd_total !== 32'd0 || rd_wrong !== 32'd0) begin
      miscompares++;
      $display("FAIL ignore_incorrect: got %0d/%0d want 0/0", rd_total, rd_wrong);
    end
    rd_sel = 2'd0;
  endtask

  task automatic test_overflow();
    clear = 1'b1;
    step_clk();
    clear    = 1'b0;
    fb_valid = 4'b0010;
    for (int i = 0; i < 300; i++) step_clk();
    fb_valid = '0;
    rd_sel = 2'd1;
    #1;
    vectors++;
    if (s_total !== 8'd255 || s_ovf !== 4'b0010) begin
      miscompares++;
      $display("FAIL ovf_saturate: got total=%0d ovf=%b want 255 0010", s_total, s_ovf);
    end
    vectors++;
    if (w_total !== 8'd44 || w_ovf !== 4'b0010) begin
      miscompares++;
      $display("FAIL ovf_wrap: got total=%0d ovf=%b want 44 0010", w_total, w_ovf);
    end
    vectors++;
    if (s_wrong !== 8'd0 || w_wrong !== 8'd0) begin
      miscompares++;
      $display("FAIL ovf_wrong: got %0d/%0d want 0/0", s_wrong, w_wrong);
    end
    vectors++;
    if (rd_total !== m_total[1] || ovf !== 3'b000) begin
      miscompares++;
      $display("FAIL ovf_wide: got total=%0d ovf=%b want %0d 000", rd_total, ovf, m_total[1]);
    end
    clear = 1'b1;
    step_clk();
    clear = 1'b0;
    vectors++;
    if (s_total !== 8'd0 || w_total !== 8'd0 || s_ovf !== 4'b0000 || w_ovf !== 4'b0000) begin
      miscompares++;
      $display("FAIL ovf_clear: got %0d/%0d ovf %b/%b want 0/0 0000/0000", s_total, w_total, s_ovf, w_ovf);
    end
    rd_sel = 2'd0;
  endtask

  task automatic test_window();
    snap_t exp;
    int    npulse;
    npulse = 0;
    vectors++;
    if (snap_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL window_pre_valid: got %b want 0", snap_valid);
    end
    clear = 1'b1;
    step_clk();
    clear      = 1'b0;
    fb_valid   = 4'b0001;
    window_len = 16'd0;
    step_clk();
    for (int i = 0; i < 16; i++) begin
      window_len   = (i < 12) ? 16'd4 : (i < 15) ? 16'd8 : 16'd2;
      fb_incorrect = (i % 3 == 0) ? 4'b0001 : 4'b0000;
      step_clk();
      vectors++;
      if (snap_pulse !== m_pulse) begin
        miscompares++;
        $display("FAIL window_pulse step %0d: got %b want %b", i, snap_pulse, m_pulse);
      end
      if (snap_pulse === 1'b1) npulse++;
      if (m_pulse) begin
        exp = sq.pop_front();
        vectors++;
        if (rd_snap_total !== exp.tot[0] || rd_snap_wrong !== exp.wrg[0]) begin
          miscompares++;
          $display("FAIL window_snap step %0d: got %0d/%0d want %0d/%0d", i, rd_snap_total, rd_snap_wrong, exp.tot[0], exp.wrg[0]);
        end
        vectors++;
        if (snap_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL window_valid step %0d: got %b want 1", i, snap_valid);
        end
      end
    end
    fb_valid = '0; fb_incorrect = '0; window_len = '0;
    vectors++;
    if (npulse !== 4) begin
      miscompares++;
      $display("FAIL window_count: got %0d want 4", npulse);
    end
  endtask

  task automatic test_clear_snap();
    snap_t exp;
    clear = 1'b1;
    step_clk();
    clear    = 1'b0;
    fb_valid = 4'b0001;
    repeat (7) step_clk();
    snap_req = 1'b1;
    clear    = 1'b1;
    step_clk();
    snap_req = 1'b0;
    clear    = 1'b0;
    fb_valid = '0;
    vectors++;
    if (snap_pulse !== 1'b1 || sq.size() != 1) begin
      miscompares++;
      $display("FAIL clrsnap_pulse: got %b want 1", snap_pulse);
    end
    if (sq.size() > 0) begin
      exp = sq.pop_front();
      vectors++;
      if (rd_snap_total !== exp.tot[0] || rd_snap_total !== 32'd7) begin
        miscompares++;
        $display("FAIL clrsnap_snap: got %0d want %0d", rd_snap_total, exp.tot[0]);
      end
    end
    vectors++;
    if (rd_total !== m_total[0] || rd_total !== 32'd0) begin
      miscompares++;
      $display("FAIL clrsnap_live: got %0d want %0d", rd_total, m_total[0]);
    end
    clear = 1'b1;
    step_clk();
    clear = 1'b0;
    vectors++;
    if (rd_snap_total !== 32'd7 || snap_valid !== 1'b1 || snap_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL clrsnap_hold: got snap=%0d valid=%b pulse=%b want 7 1 0", rd_snap_total, snap_valid, snap_pulse);
    end
  endtask

  task automatic test_async_reset();
    snap_t exp;
    clear = 1'b1;
    step_clk();
    clear    = 1'b0;
    fb_valid = 4'b0001;
    repeat (3) step_clk();
    snap_req = 1'b1;
    step_clk();
    snap_req = 1'b0;
    if (sq.size() > 0) exp = sq.pop_front();
    step_clk();
    fb_valid = '0;
    vectors++;
    if (rd_total !== m_total[0] || rd_snap_total !== exp.tot[0] || rd_total !== 32'd5 || rd_snap_total !== 32'd3) begin
      miscompares++;
      $display("FAIL areset_pre: got %0d/%0d want %0d/%0d", rd_total, rd_snap_total, m_total[0], exp.tot[0]);
    end
    rd_sel = 2'd3;
    #1;
    vectors++;
    if (rd_total !== 32'd0 || rd_wrong !== 32'd0 || rd_snap_total !== 32'd0 || rd_snap_wrong !== 32'd0) begin
      miscompares++;
      $display("FAIL oob_sel_live: got %0d/%0d/%0d/%0d want 0/0/0/0", rd_total, rd_wrong, rd_snap_total, rd_snap_wrong);
    end
    rd_sel = 2'd0;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (rd_total !== 32'd0 || rd_wrong !== 32'd0 || rd_snap_total !== 32'd0 || rd_snap_wrong !== 32'd0) begin
      miscompares++;
      $display("FAIL areset_counts: got %0d/%0d/%0d/%0d want 0/0/0/0", rd_total, rd_wrong, rd_snap_total, rd_snap_wrong);
    end
    vectors++;
    if (snap_valid !== 1'b0 || snap_pulse !== 1'b0 || ovf !== 3'b000) begin
      miscompares++;
      $display("FAIL areset_flags: got valid=%b pulse=%b ovf=%b want 0 0 000", snap_valid, snap_pulse, ovf);
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rd_sel = 2'd3;
    #1;
    vectors++;
    if (rd_total !== 32'd0 || rd_wrong !== 32'd0 || rd_snap_total !== 32'd0 || rd_snap_wrong !== 32'd0) begin
      miscompares++;
      $display("FAIL oob_sel_post: got %0d/%0d/%0d/%0d want 0/0/0/0", rd_total, rd_wrong, rd_snap_total, rd_snap_wrong);
    end
    rd_sel = 2'd0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_ignore_incorrect();
    test_overflow();
    test_window();
    test_clear_snap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
